// File: rtl/float_req_pkg.sv
// Shared types and sizes for the float requester and its result checker.
package float_req_pkg;

  localparam int unsigned OP_W  = 64;
  localparam int unsigned RES_W = 128;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 16'd200;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_e;

endpackage

// File: rtl/float_req_check.sv
// Result checker: flags a responder result that differs from the operand
// concatenation implied by select. Only instantiated with FLOAT_REQ_CHECK_EN.
module float_req_check
  import float_req_pkg::*;
(
  input  logic [OP_W-1:0]  float1,
  input  logic [OP_W-1:0]  float2,
  input  logic             select,
  input  logic [RES_W-1:0] out,
  output logic             mismatch
);

  logic [RES_W-1:0] expected;

  // Expected result ordering is chosen by the select sent to the responder
  always_comb begin
    expected = select ? {float1, float2} : {float2, float1};
    mismatch = (out != expected);
  end

endmodule

// File: rtl/float_requester.sv
// Float requester: accepts one operand pair, issues it to a responder, waits
// for completion or timeout, and holds the response until consumed.
// Optional macro FLOAT_REQ_CHECK_EN enables result checking (rsp_mismatch);
// without it rsp_mismatch is tied low and no comparator exists.
module float_requester
  import float_req_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
  input  logic             clock_50M,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_a,
  input  logic [OP_W-1:0]  req_b,
  input  logic             req_sel,
  output logic [OP_W-1:0]  float1,
  output logic [OP_W-1:0]  float2,
  output logic             select,
  output logic             start,
  input  logic             done,
  input  logic [RES_W-1:0] out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             rsp_mismatch,
  output logic             late_done
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  float1_q, float1_d;
  logic [OP_W-1:0]  float2_q, float2_d;
  logic             select_q, select_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RES_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             late_done_q, late_done_d;

`ifdef FLOAT_REQ_CHECK_EN
  logic             rsp_mismatch_q, rsp_mismatch_d;
  logic             chk_mismatch;

  float_req_check u_check (
    .float1   (float1_q),
    .float2   (float2_q),
    .select   (select_q),
    .out      (out),
    .mismatch (chk_mismatch)
  );
`endif

  // State register
  always_ff @(posedge clock_50M) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: done wins over the timeout on the threshold cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done || (wait_cnt_q == TIMEOUT_CYCLES)) state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the current state
  always_comb begin
    req_ready = (state_q == IDLE);
    start     = (state_q == ISSUE);
    rsp_valid = (state_q == HOLD);
  end

  // Datapath next values: operand capture, wait counter, response capture
  always_comb begin
    float1_d      = float1_q;
    float2_d      = float2_q;
    select_d      = select_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    late_done_d   = late_done_q | (done && (state_q != WAIT));
`ifdef FLOAT_REQ_CHECK_EN
    rsp_mismatch_d = rsp_mismatch_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          float1_d = req_a;
          float2_d = req_b;
          select_d = req_sel;
        end
      end
      ISSUE: wait_cnt_d = '0;
      WAIT: begin
        if (done) begin
          rsp_data_d    = out;
          rsp_timeout_d = 1'b0;
`ifdef FLOAT_REQ_CHECK_EN
          rsp_mismatch_d = chk_mismatch;
`endif
        end else if (wait_cnt_q == TIMEOUT_CYCLES) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
`ifdef FLOAT_REQ_CHECK_EN
          rsp_mismatch_d = 1'b0;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      float1_q      <= '0;
      float2_q      <= '0;
      select_q      <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      late_done_q   <= 1'b0;
    end else begin
      float1_q      <= float1_d;
      float2_q      <= float2_d;
      select_q      <= select_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      late_done_q   <= late_done_d;
    end
  end

`ifdef FLOAT_REQ_CHECK_EN
  // Mismatch flag register, present only when checking is built in
  always_ff @(posedge clock_50M) begin
    if (reset) rsp_mismatch_q <= 1'b0;
    else       rsp_mismatch_q <= rsp_mismatch_d;
  end
  assign rsp_mismatch = rsp_mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign float1      = float1_q;
  assign float2      = float2_q;
  assign select      = select_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign late_done   = late_done_q;

endmodule

// File: tb/tb_float_requester.sv
// Testbench for float_requester: directed scenarios plus randomized
// transactions, checked every cycle against a transaction-level model.
module tb_float_requester;

  localparam logic [15:0] TO = 16'd200;
`ifdef FLOAT_REQ_CHECK_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic         clock_50M = 1'b0;
  logic         reset     = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_sel   = 1'b0;
  logic         done      = 1'b0;
  logic         rsp_ready = 1'b0;
  logic [63:0]  req_a     = '0;
  logic [63:0]  req_b     = '0;
  logic [127:0] out       = '0;
  logic         req_ready, select, start, rsp_valid, rsp_timeout, rsp_mismatch, late_done;
  logic [63:0]  float1, float2;
  logic [127:0] rsp_data;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clock_50M = ~clock_50M;

  float_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clock_50M    (clock_50M),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .float1       (float1),
    .float2       (float2),
    .select       (select),
    .start        (start),
    .done         (done),
    .out          (out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .rsp_mismatch (rsp_mismatch),
    .late_done    (late_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  task automatic tick();
    @(negedge clock_50M);
  endtask

  // Transaction-level model: one outstanding request, aged in cycles since accept
  bit           m_init = 1'b0;
  bit           m_busy, m_have, m_late, m_sel, m_to, m_mis, m_in_wait;
  int           m_age;
  logic [63:0]  m_f1, m_f2;
  logic [127:0] m_data;

  always @(posedge clock_50M) begin
    if (reset) begin
      m_init = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_late = 1'b0;
      m_sel = 1'b0; m_to = 1'b0; m_mis = 1'b0; m_age = 0;
      m_f1 = '0; m_f2 = '0; m_data = '0;
    end else if (m_init) begin
      m_in_wait = m_busy && !m_have && (m_age >= 1);
      if (done && !m_in_wait) m_late = 1'b1;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1; m_have = 1'b0; m_age = 0;
          m_f1 = req_a; m_f2 = req_b; m_sel = req_sel;
        end
      end else if (m_have) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        if (m_in_wait) begin
          if (done) begin
            m_have = 1'b1; m_data = out; m_to = 1'b0;
            m_mis  = CK_EN && (out != (m_sel ? {m_f1, m_f2} : {m_f2, m_f1}));
          end else if (m_age - 1 == int'(TO)) begin
            m_have = 1'b1; m_data = '0; m_to = 1'b1; m_mis = 1'b0;
          end
        end
        m_age++;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock_50M) begin
    if (m_init) begin
      chk("req_ready", req_ready, !m_busy);
      chk("start", start, m_busy && !m_have && (m_age == 0));
      chk("rsp_valid", rsp_valid, m_busy && m_have);
      chk("late_done", late_done, m_late);
      chk("float1", float1, m_f1);
      chk("float2", float2, m_f2);
      chk("select", select, m_sel);
      if (m_busy && m_have) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_timeout", rsp_timeout, m_to);
        chk("rsp_mismatch", rsp_mismatch, m_mis);
      end
    end
  end

  // Responder stub: pulses done resp_delay cycles after seeing start
  int resp_delay   = 5;
  bit resp_corrupt = 1'b0;
  bit resp_en      = 1'b1;
  int inj_req      = 0;
  int inj_ack      = 0;
  int resp_cnt     = -1;

  always @(negedge clock_50M) begin
    done = 1'b0;
    out  = {$urandom, $urandom, $urandom, $urandom};
    if (reset) begin
      resp_cnt = -1;
    end else if (start && resp_en) begin
      if (resp_delay == 0) done = 1'b1;
      else resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        done = 1'b1;
        resp_cnt = -1;
      end
    end
    if (done)
      out = (resp_corrupt || select) ? {float1, float2} : {float2, float1};
    if (inj_req != inj_ack) begin
      inj_ack = inj_req;
      done = 1'b1;
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_sel = s;
    while (!req_ready && n < 400) begin tick(); n++; end
    if (!req_ready) fail_bound("accept_wait");
    tick();
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_sel = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(input int budget, output int lat, output int starts);
    lat = 0; starts = 0;
    while (!rsp_valid && lat < budget) begin
      tick(); lat++;
      if (start) starts++;
    end
    if (!rsp_valid) fail_bound("rsp_wait");
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, starts, n, cnt;
    bit hs;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_timeout", rsp_timeout, 1'b0);
    chk("rst_mismatch", rsp_mismatch, 1'b0);
    chk("rst_late_done", late_done, 1'b0);
    chk("rst_float1", float1, 64'h0);
    chk("rst_float2", float2, 64'h0);
    chk("rst_select", select, 1'b0);
    chk("rst_rsp_data", rsp_data, 128'h0);
    reset = 1'b0;
    tick();

    // Normal response after 128 cycles
    resp_delay = 128;
    send(64'h1111, 64'h2222, 1'b1);
    chk("norm_start", start, 1'b1);
    wait_rsp(400, lat, starts);
    chk("norm_latency", 32'(lat), 32'd129);
    chk("norm_one_start", 32'(starts), 32'd0);
    chk("norm_data", rsp_data, {64'h1111, 64'h2222});
    chk("norm_model_data", m_data, {64'h1111, 64'h2222});
    chk("norm_timeout", rsp_timeout, 1'b0);
    chk("norm_mismatch", rsp_mismatch, 1'b0);
    consume();

    // Swapped order, then a responder returning the wrong order
    resp_delay = 10;
    send(64'h1111, 64'h2222, 1'b0);
    wait_rsp(400, lat, starts);
    chk("swap_data", rsp_data, {64'h2222, 64'h1111});
    chk("swap_mismatch", rsp_mismatch, 1'b0);
    consume();
    resp_corrupt = 1'b1;
    send(64'h1111, 64'h2222, 1'b0);
    wait_rsp(400, lat, starts);
    chk("swapbad_data", rsp_data, {64'h1111, 64'h2222});
    chk("swapbad_mismatch", rsp_mismatch, CK_EN);
    consume();
    resp_corrupt = 1'b0;

    // Timeout: responder silent
    resp_en = 1'b0;
    send(64'h5, 64'h6, 1'b1);
    wait_rsp(400, lat, starts);
    chk("to_latency", 32'(lat), 32'd202);
    chk("to_timeout", rsp_timeout, 1'b1);
    chk("to_data", rsp_data, 128'h0);
    chk("to_mismatch", rsp_mismatch, 1'b0);
    consume();
    resp_en = 1'b1;

    // Done exactly on the threshold cycle wins
    resp_delay = 201;
    send(64'hAAAA, 64'hBBBB, 1'b1);
    wait_rsp(400, lat, starts);
    chk("race_latency", 32'(lat), 32'd202);
    chk("race_timeout", rsp_timeout, 1'b0);
    chk("race_data", rsp_data, {64'hAAAA, 64'hBBBB});
    consume();

    // Backpressure with a second request pending
    resp_delay = 3;
    send(64'h77, 64'h88, 1'b1);
    wait_rsp(400, lat, starts);
    req_valid = 1'b1; req_a = 64'h99; req_b = 64'hCC; req_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, {64'h77, 64'h88});
      chk("bp_req_ready", req_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_f1", float1, 64'h99);
    chk("bp_second_start", start, 1'b1);
    wait_rsp(400, lat, starts);
    chk("bp_second_data", rsp_data, {64'hCC, 64'h99});
    consume();

    // Reset while waiting, then a late done
    resp_delay = 120;
    send(64'h1, 64'h2, 1'b1);
    repeat (50) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("rstw_late0", late_done, 1'b0);
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (rsp_valid) cnt++;
      tick();
    end
    chk("rstw_no_rsp", 32'(cnt), 32'd0);
    inj_req++;
    repeat (3) tick();
    chk("rstw_late1", late_done, 1'b1);

    // Randomized transactions with random backpressure and stray done pulses
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       resp_delay = int'($urandom_range(195, 205));
        1:       resp_delay = 0;
        default: resp_delay = int'($urandom_range(1, 60));
      endcase
      resp_corrupt = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) tick();
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      n = 0; hs = 1'b0;
      while (!hs && n < 500) begin
        rsp_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 63) == 0) inj_req++;
        hs = rsp_valid && rsp_ready;
        tick();
        n++;
      end
      rsp_ready = 1'b0;
      if (!hs) fail_bound("rand_handshake");
    end

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
